// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with memory ready handshake, wait-state timeout and illegal-opcode detection.
module mips_multicycle_control #(
    parameter int                 OP_W     = 6,
    parameter int                 ALUOP_W  = 3,
    parameter logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000),
    parameter logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011),
    parameter logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011),
    parameter logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100),
    parameter logic [OP_W-1:0]    OP_BNE   = OP_W'(6'b000101),
    parameter logic [OP_W-1:0]    OP_ADDI  = OP_W'(6'b001000),
    parameter logic [OP_W-1:0]    OP_J     = OP_W'(6'b000010),
    parameter int                 TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal,
    output logic               bus_err,
    output logic [3:0]         state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [ALUOP_W-1:0] ALU_FUNCT = '0;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b011);

    // A zero TIMEOUT still needs a legal (1-bit) counter even though it is never compared.
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             is_wait;
    logic             timeout;
    logic             is_legal;

    assign is_wait  = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    assign is_legal = (opcode == OP_RTYPE) || (opcode == OP_LW)  || (opcode == OP_SW) ||
                      (opcode == OP_BEQ)   || (opcode == OP_BNE) || (opcode == OP_ADDI) ||
                      (opcode == OP_J);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            assign timeout = is_wait && !mem_ready && (cnt_reg == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready)    state_next = S_DECODE;
                else if (timeout) state_next = S_FETCH;
            end
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW))         state_next = S_MEMADR;
                else if (opcode == OP_RTYPE)                        state_next = S_EXECUTE;
                else if ((opcode == OP_BEQ) || (opcode == OP_BNE))  state_next = S_BRANCH;
                else if (opcode == OP_ADDI)                         state_next = S_ADDIEXEC;
                else if (opcode == OP_J)                            state_next = S_JUMP;
                else                                                state_next = S_FETCH;
            end
            S_MEMADR:   state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)    state_next = S_MEMWB;
                else if (timeout) state_next = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready || timeout) state_next = S_FETCH;
            end
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEXEC: state_next = S_ADDIWB;
            default:    state_next = S_FETCH;
        endcase
    end

    // A timeout in FETCH keeps the state code unchanged, so it must clear the counter explicitly.
    always_comb begin
        cnt_next = cnt_reg;
        if (timeout || !is_wait || (state_next != state_reg)) begin
            cnt_next = '0;
        end else if (!mem_ready && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outputs are forced low while reset is high, even though FETCH is state 0.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_FUNCT;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        state_o    = 4'd0;
        if (!reset) begin
            state_o = state_reg;
            bus_err = timeout;
            case (state_reg)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = ALU_ADD;
                    illegal   = !is_legal;
                end
                S_MEMADR, S_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'b01;
                    branch    = (opcode == OP_BEQ);
                    branch_ne = (opcode == OP_BNE) && (opcode != OP_BEQ);
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Parametrised multicycle successor to the single-cycle main decoder in the MIPS datapath.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. This lets the datapath share one memory and one ALU.
- Adds over the single-cycle decoder: a memory ready handshake, a wait-state timeout, illegal-opcode detection, and configurable opcodes and ALU-op width.
- Sits between the instruction register's opcode field and the shared datapath muxes and write enables.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, alu_op width. Must be >= 3; encodings are zero-extended.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, LW opcode.
- OP_SW, 6'b101011, SW opcode.
- OP_BEQ, 6'b000100, BEQ opcode.
- OP_BNE, 6'b000101, BNE opcode.
- OP_ADDI, 6'b001000, ADDI opcode.
- OP_J, 6'b000010, J opcode.
- TIMEOUT, 16, maximum consecutive not-ready wait cycles. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  OP_W  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load enable.
- pc_write  out  1  unconditional PC write.
- branch  out  1  PC write if zero (BEQ).
- branch_ne  out  1  PC write if not zero (BNE).
- pc_src  out  2  PC mux: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- alu_op  out  ALUOP_W  ALU operation: 000 = funct decode, 001 = add, 011 = sub.
- reg_dst  out  1  register destination: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register-file write enable.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- bus_err  out  1  one-cycle pulse on wait timeout.
- state_o  out  4  current state, for debug.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- While reset is high, every output is 0 (state_o = 0).
- After reset releases, state = FETCH and the wait counter = 0.
- Reset asserted mid-instruction aborts it immediately; no partial writes complete.
- Outputs are Moore-decoded from state. Exceptions: the handshake-qualified strobes and the illegal/bus_err pulses also depend on the current inputs. Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable and return to FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add.
  - ir_write and pc_write = mem_ready.
  - Go to DECODE on mem_ready; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add. Next state by opcode:
  - LW or SW -> MEMADR.
  - RTYPE -> EXECUTE.
  - BEQ or BNE -> BRANCH.
  - ADDI -> ADDIEXEC.
  - J -> JUMP.
  - Any other opcode: illegal=1 this cycle, then FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, iord=1, held until mem_ready. Then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=funct. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01.
  - branch=1 when opcode==OP_BEQ; branch_ne=1 when opcode==OP_BNE. Never both.
  - Then FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=add. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- JUMP: pc_write=1, pc_src=10. Then FETCH.
- Wait counter (applies in FETCH, MEMRD and MEMWR, the wait states):
  - Cleared outside the wait states and on every state change.
  - Increments on each mem_ready=0 cycle in a wait state.
  - If TIMEOUT != 0, count == TIMEOUT-1 and mem_ready=0: bus_err=1 this cycle, next state FETCH, counter cleared.
  - No PC, IR, register or memory update occurs on a timeout.
  - mem_ready=1 in that same cycle wins: normal transition, no bus_err.
  - Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- Latency with mem_ready tied high: R-type, ADDI and SW take 4 cycles; LW takes 5; BEQ, BNE and J take 3.

Test Plan:
- Reset, mem_ready=1, opcode=100011 (LW) -> state_o sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. pc_write=1 only in state 0.
- opcode=101011 (SW), mem_ready low for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles with iord=1, then state 0. reg_write stays 0 throughout.
- opcode=000101 (BNE) -> in state 8: branch_ne=1, branch=0, pc_src=01, alu_op=011, alu_src_a=1. Next state 0.
- opcode=111111 in DECODE -> illegal=1 for exactly 1 cycle, next state 0. No reg_write, mem_write or pc_write pulse.
- TIMEOUT=4, mem_ready held 0 from FETCH entry -> bus_err=1 in the 4th cycle only. ir_write and pc_write stay 0. FETCH re-enters with counter 0. Repeat with mem_ready=1 in the 4th cycle -> no bus_err, state 1.
- Assert reset asynchronously mid-MEMWR -> all outputs 0 before the next clk edge. After release, state_o=0 and the fetch starts cleanly.
